vending_machine_gen: RTL and testbench
======================================

Name: vending_machine_gen

Overview:
- Parametrised successor to the fixed 4x4 vending controller.
- Adds configurable slot grid and money width, a per-coin deposit interface, and a writable price table.
- Tracks per-slot stock with sold-out detection, holds a pending selection until funds arrive, and supports cancel/refund plus selection timeout.
- Sits between the coin acceptor / keypad front end and the dispense motor and change-hopper drivers.

Parameters:
- ROWS, 4: number of letter rows (keys A..).
- COLS, 4: number of digit columns (keys 1..).
- MONEY_W, 16: width of credit, price and change, in cents.
- STOCK_W, 4: width of the per-slot stock counter.
- INIT_STOCK, 3: stock loaded into every slot at reset and on restock.
- PRICE_BASE, 100: reset price component, in cents.
- PRICE_STEP, 25: reset price increment, in cents.
- TIMEOUT, 64: cycles in ROW state with no column press before the selection is abandoned.
- Localparam IDX_W = clog2(ROWS*COLS).
- Slot index idx = row*COLS + col.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle pulse; a coin is deposited.
- coin_value  in  MONEY_W  value of the coin, sampled when coin_valid=1.
- row_sel  in  ROWS  row keys, one-hot, level-sampled each cycle.
- col_sel  in  COLS  column keys, one-hot, level-sampled each cycle.
- cancel  in  1  refund request.
- cfg_we  in  1  price-table write strobe.
- cfg_idx  in  IDX_W  slot index for a price write or restock.
- cfg_price  in  MONEY_W  new price for the slot.
- restock  in  1  reload stock[cfg_idx] to INIT_STOCK.
- credit  out  MONEY_W  current accumulated credit.
- price  out  MONEY_W  price of the last checked slot.
- change  out  MONEY_W  change or refund amount; valid with change_valid.
- change_valid  out  1  one-cycle pulse.
- selection  out  IDX_W  index of the slot being dispensed.
- dispensing  out  1  one-cycle pulse; a vend occurs.
- sold_out  out  1  one-cycle pulse.
- invalid  out  1  one-cycle pulse; illegal key sequence.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 and state goes to IDLE.
  - Credit clears; every slot's stock is set to INIT_STOCK.
  - price_tab[idx] = PRICE_BASE + PRICE_STEP*(row+col).
  - Reset deassertion is synchronised internally; the first state action occurs on the 2nd rising edge after deassertion.
- Key press: a cycle where the key vector is nonzero and was zero in the previous cycle (edge-detected). A non-one-hot press gives invalid=1 and is otherwise ignored.
- Credit:
  - credit_next = base + (coin_valid ? coin_value : 0), saturating at 2^MONEY_W-1.
  - base = 0 in the cycle change_valid=1, otherwise base = credit.
  - A coin arriving in a dispense or refund cycle is therefore kept as new credit, never lost.
- FSM states: IDLE, ROW, CHECK, WAIT_FUNDS, DISPENSE, REFUND.
- IDLE:
  - Row press: latch the row and go to ROW.
  - Column press: invalid pulse, stay in IDLE.
  - cancel with credit>0: go to REFUND.
- ROW:
  - Column press: latch idx and go to CHECK.
  - Another row press: invalid pulse; the new row replaces the old one and the timeout counter restarts.
  - TIMEOUT cycles without a column press: go to IDLE.
  - cancel: go to REFUND if credit>0, otherwise IDLE.
- CHECK (exactly 1 cycle):
  - price <= price_tab[idx].
  - stock[idx]==0: sold_out pulse, go to IDLE, credit retained.
  - Else if credit >= price: go to DISPENSE.
  - Else: go to WAIT_FUNDS.
- WAIT_FUNDS:
  - price is held.
  - Each cycle, if credit >= price (credit including a coin just registered): go to DISPENSE.
  - Row press: abandon the pending selection and go to ROW.
  - cancel: go to REFUND.
- DISPENSE (1 cycle):
  - dispensing=1, selection=idx.
  - change = credit - price, change_valid=1.
  - stock[idx] decrements; next state IDLE.
- REFUND (1 cycle): change = credit, change_valid=1, next state IDLE.
- cancel is ignored in CHECK and DISPENSE.
- Latency:
  - Column press with sufficient credit: dispensing asserts 2 cycles after the press is registered.
  - Funds arriving in WAIT_FUNDS: dispensing asserts 1 cycle after the credit update.
- price holds its value until the next CHECK; it is never cleared except by reset.
- Same-cycle conflicts:
  - cfg_we during CHECK of the same idx: CHECK uses the old price; the new price applies afterwards.
  - restock on the same cycle as DISPENSE of the same slot: restock wins (stock = INIT_STOCK).
  - restock/cfg_we are accepted in every state.
- Stock never underflows, because the sold-out check precedes every decrement.

Test Plan:
- 4x coin 25, then A, then 1 -> CHECK price=100; next cycle dispensing=1, selection=0, change=0, change_valid=1, credit=0.
- coins 100,100, then A, 3 -> price=150, selection=2, change=50.
- B, 4 with credit=0 -> WAIT_FUNDS with price=200; coin 100 -> no vend; coin 100 -> dispensing=1, selection=7, change=0.
- credit 200; press 2 in IDLE -> invalid pulse; A then C -> invalid pulse, row=C; then 1 -> selection=8, price=150, change=50.
- buy A1 three times with exact 100 -> 3 vends; 4th attempt -> sold_out pulse, credit=100 retained; cancel -> change=100, credit=0; restock cfg_idx=0 -> A1 vends again.
- credit 100, select D1 (price=175), pull reset low in WAIT_FUNDS -> all outputs 0 immediately, stock reloaded; after release, cfg_we idx=0 price=60 then a 60c vend of A1 -> change=0.

Source files
------------

// File: rtl/vending_machine_gen.sv
// Parametrised vending controller: coin credit, keypad row/column selection,
// per-slot price and stock, dispense plus change/refund outputs.

module vending_slot #(
  parameter int MONEY_W    = 16,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 3,
  parameter int RST_PRICE  = 100
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic               price_we_i,
  input  logic [MONEY_W-1:0] price_i,
  input  logic               restock_i,
  input  logic               dec_i,
  output logic [MONEY_W-1:0] price_o,
  output logic               empty_o
);
  logic [MONEY_W-1:0] price_q;
  logic [STOCK_W-1:0] stock_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      price_q <= MONEY_W'(RST_PRICE);
      stock_q <= STOCK_W'(INIT_STOCK);
    end else if (en_i) begin
      if (price_we_i) price_q <= price_i;
      // a restock landing on the dispense cycle wins over the decrement
      if (restock_i)                       stock_q <= STOCK_W'(INIT_STOCK);
      else if (dec_i && stock_q != '0)     stock_q <= stock_q - 1'b1;
    end
  end

  assign price_o = price_q;
  assign empty_o = (stock_q == '0);
endmodule

module vending_machine_gen #(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int MONEY_W    = 16,
  parameter  int STOCK_W    = 4,
  parameter  int INIT_STOCK = 3,
  parameter  int PRICE_BASE = 100,
  parameter  int PRICE_STEP = 25,
  parameter  int TIMEOUT    = 64,
  localparam int IDX_W      = $clog2(ROWS*COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coin_valid,
  input  logic [MONEY_W-1:0] coin_value,
  input  logic [ROWS-1:0]    row_sel,
  input  logic [COLS-1:0]    col_sel,
  input  logic               cancel,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [MONEY_W-1:0] cfg_price,
  input  logic               restock,
  output logic [MONEY_W-1:0] credit,
  output logic [MONEY_W-1:0] price,
  output logic [MONEY_W-1:0] change,
  output logic               change_valid,
  output logic [IDX_W-1:0]   selection,
  output logic               dispensing,
  output logic               sold_out,
  output logic               invalid
);
  localparam int N     = ROWS * COLS;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_CHECK, S_WAIT, S_DISP, S_REFUND
  } state_t;

  state_t             state_q, state_d;
  logic               run_q;
  logic [ROWS-1:0]    row_q, row_prev_q;
  logic [COLS-1:0]    col_q, col_prev_q;
  logic [IDX_W-1:0]   row_idx_q, row_idx_d, idx_q, idx_d;
  logic [MONEY_W-1:0] price_q, price_d, credit_q, credit_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               sold_out_q, sold_out_d, invalid_q, invalid_d;

  logic [N-1:0][MONEY_W-1:0] slot_price;
  logic [N-1:0]              slot_empty;

  logic               row_hit, col_hit, row_1h, col_1h, row_ok, col_ok;
  logic [IDX_W-1:0]   row_enc, col_enc, sel_idx;
  logic [MONEY_W-1:0] tab_price, base;
  logic [MONEY_W:0]   sum;

  // Reset release is retimed by one flop; logic starts acting one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    vending_slot #(
      .MONEY_W   (MONEY_W),
      .STOCK_W   (STOCK_W),
      .INIT_STOCK(INIT_STOCK),
      .RST_PRICE (PRICE_BASE + PRICE_STEP * (i / COLS + i % COLS))
    ) u_slot (
      .clk       (clk),
      .rst_n_i   (reset),
      .en_i      (run_q),
      .price_we_i(cfg_we && cfg_idx == IDX_W'(i)),
      .price_i   (cfg_price),
      .restock_i (restock && cfg_idx == IDX_W'(i)),
      .dec_i     (dispensing && idx_q == IDX_W'(i)),
      .price_o   (slot_price[i]),
      .empty_o   (slot_empty[i])
    );
  end

  assign tab_price = slot_price[idx_q];

  always_comb begin
    row_hit = (row_q != '0) && (row_prev_q == '0);
    col_hit = (col_q != '0) && (col_prev_q == '0);
    row_1h  = ((row_q & (row_q - 1'b1)) == '0);
    col_1h  = ((col_q & (col_q - 1'b1)) == '0);
    row_ok  = row_hit && row_1h;
    col_ok  = col_hit && col_1h;
    row_enc = '0;
    col_enc = '0;
    for (int r = 0; r < ROWS; r++) if (row_q[r]) row_enc = IDX_W'(r);
    for (int c = 0; c < COLS; c++) if (col_q[c]) col_enc = IDX_W'(c);
    sel_idx = IDX_W'(int'(row_idx_q) * COLS + int'(col_enc));
  end

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    idx_d      = idx_q;
    price_d    = price_q;
    tmr_d      = tmr_q;
    sold_out_d = 1'b0;
    invalid_d  = (row_hit && !row_1h) || (col_hit && !col_1h);
    case (state_q)
      S_IDLE: begin
        if (cancel && credit_q != '0) state_d = S_REFUND;
        else if (row_ok) begin
          row_idx_d = row_enc;
          tmr_d     = '0;
          state_d   = S_ROW;
        end else if (col_ok) invalid_d = 1'b1;
      end
      S_ROW: begin
        if (cancel) state_d = (credit_q != '0) ? S_REFUND : S_IDLE;
        else if (col_ok) begin
          idx_d   = sel_idx;
          state_d = S_CHECK;
        end else if (row_ok) begin
          invalid_d = 1'b1;
          row_idx_d = row_enc;
          tmr_d     = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) state_d = S_IDLE;
        else tmr_d = tmr_q + 1'b1;
      end
      S_CHECK: begin
        price_d = tab_price;
        if (slot_empty[idx_q]) begin
          sold_out_d = 1'b1;
          state_d    = S_IDLE;
        end else if (credit_q >= tab_price) state_d = S_DISP;
        else state_d = S_WAIT;
      end
      S_WAIT: begin
        if (credit_q >= price_q) state_d = S_DISP;
        else if (cancel) state_d = S_REFUND;
        else if (row_ok) begin
          row_idx_d = row_enc;
          tmr_d     = '0;
          state_d   = S_ROW;
        end
      end
      S_DISP, S_REFUND: state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  assign dispensing   = (state_q == S_DISP);
  assign change_valid = (state_q == S_DISP) || (state_q == S_REFUND);
  assign change       = dispensing ? (credit_q - price_q) :
                        change_valid ? credit_q : '0;
  assign selection    = dispensing ? idx_q : '0;
  assign credit       = credit_q;
  assign price        = price_q;
  assign sold_out     = sold_out_q;
  assign invalid      = invalid_q;

  // Credit paid out this cycle is dropped, but a coin arriving now is kept.
  always_comb begin
    base     = change_valid ? '0 : credit_q;
    sum      = {1'b0, base} + {1'b0, (coin_valid ? coin_value : {MONEY_W{1'b0}})};
    credit_d = sum[MONEY_W] ? {MONEY_W{1'b1}} : sum[MONEY_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      row_prev_q <= '0;
      col_q      <= '0;
      col_prev_q <= '0;
      row_idx_q  <= '0;
      idx_q      <= '0;
      price_q    <= '0;
      credit_q   <= '0;
      tmr_q      <= '0;
      sold_out_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else if (run_q) begin
      state_q    <= state_d;
      row_q      <= row_sel;
      row_prev_q <= row_q;
      col_q      <= col_sel;
      col_prev_q <= col_q;
      row_idx_q  <= row_idx_d;
      idx_q      <= idx_d;
      price_q    <= price_d;
      credit_q   <= credit_d;
      tmr_q      <= tmr_d;
      sold_out_q <= sold_out_d;
      invalid_q  <= invalid_d;
    end
  end
endmodule

// File: tb/tb_vending_machine_gen.sv
// Scoreboard bench for vending_machine_gen: expected payouts are queued before
// each key sequence and popped when change_valid fires.

module tb_vending_machine_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        coin_valid = 1'b0;
  logic [15:0] coin_value = '0;
  logic [3:0]  row_sel = '0, col_sel = '0;
  logic        cancel = 1'b0, cfg_we = 1'b0, restock = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [15:0] cfg_price = '0;
  logic [15:0] credit, price, change;
  logic        change_valid, dispensing, sold_out, invalid;
  logic [3:0]  selection;

  vending_machine_gen dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .row_sel(row_sel), .col_sel(col_sel), .cancel(cancel), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_price(cfg_price), .restock(restock),
    .credit(credit), .price(price), .change(change), .change_valid(change_valid),
    .selection(selection), .dispensing(dispensing), .sold_out(sold_out),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct { logic disp; logic [3:0] sel; logic [15:0] chg; } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  int   n_chk = 0, n_err = 0, n_inv = 0, n_so = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (invalid)  n_inv++;
      if (sold_out) n_so++;
      if (change_valid) begin
        if (exp_q.size() == 0) chk("unexpected_payout", {16'h0, change}, 32'hDEAD);
        else begin
          e_mon = exp_q.pop_front();
          chk("dispensing", 32'(dispensing), 32'(e_mon.disp));
          chk("selection",  32'(selection),  32'(e_mon.sel));
          chk("change",     32'(change),     32'(e_mon.chg));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic coin(input logic [15:0] v);
    coin_valid = 1'b1; coin_value = v;
    tick(1);
    coin_valid = 1'b0; coin_value = '0;
  endtask

  task automatic press_row(input int r);
    row_sel = 4'(1 << r); tick(2); row_sel = '0; tick(2);
  endtask

  task automatic press_col(input int c);
    col_sel = 4'(1 << c); tick(2); col_sel = '0; tick(2);
  endtask

  task automatic push(input logic d, input logic [3:0] s, input logic [15:0] c);
    exp_t e;
    e.disp = d; e.sel = s; e.chg = c;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(1); n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_cancel();
    cancel = 1'b1; tick(1); cancel = 1'b0; tick(1);
  endtask

  task automatic buy(input int r, input int c, input logic [15:0] amt,
                     input logic [15:0] chg);
    coin(amt);
    push(1'b1, 4'(r * 4 + c), chg);
    press_row(r); press_col(c);
    drain();
  endtask

  initial begin
    int i0, s0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #3;
    chk("rst_credit", 32'(credit), 0);
    chk("rst_price",  32'(price), 0);
    chk("rst_cv",     32'(change_valid), 0);
    chk("rst_disp",   32'(dispensing), 0);
    @(negedge clk) reset = 1'b1;
    tick(3);

    // 4x25 then A1
    repeat (4) coin(16'd25);
    chk("credit_100", 32'(credit), 100);
    push(1'b1, 4'd0, 16'd0);
    press_row(0); press_col(0);
    drain();
    chk("a1_price", 32'(price), 100);
    chk("a1_credit", 32'(credit), 0);

    // 200 then A3
    coin(16'd100); coin(16'd100);
    push(1'b1, 4'd2, 16'd50);
    press_row(0); press_col(2);
    drain();
    chk("a3_price", 32'(price), 150);

    // B4 with no credit waits for funds
    press_row(1); press_col(3);
    chk("b4_price", 32'(price), 200);
    coin(16'd100); tick(2);
    chk("b4_nodisp", 32'(dispensing), 0);
    chk("b4_credit", 32'(credit), 100);
    push(1'b1, 4'd7, 16'd0);
    coin(16'd100);
    drain();
    chk("b4_credit0", 32'(credit), 0);

    // illegal sequences
    coin(16'd100); coin(16'd100);
    i0 = n_inv;
    press_col(1);
    chk("inv_col_idle", n_inv - i0, 1);
    press_row(0); press_row(2);
    chk("inv_row_row", n_inv - i0, 2);
    push(1'b1, 4'd8, 16'd50);
    press_col(0);
    drain();
    chk("c1_price", 32'(price), 150);

    // sold out, refund, restock
    restock = 1'b1; cfg_idx = 4'd0; tick(1); restock = 1'b0;
    repeat (3) buy(0, 0, 16'd100, 16'd0);
    coin(16'd100);
    s0 = n_so;
    press_row(0); press_col(0);
    chk("sold_out", n_so - s0, 1);
    chk("so_credit", 32'(credit), 100);
    push(1'b0, 4'd0, 16'd100);
    do_cancel();
    drain();
    chk("refund_credit", 32'(credit), 0);
    restock = 1'b1; cfg_idx = 4'd0; tick(1); restock = 1'b0;
    buy(0, 0, 16'd100, 16'd0);

    // reset while waiting for funds on D1
    coin(16'd100);
    press_row(3); press_col(0);
    chk("d1_price", 32'(price), 175);
    #2 reset = 1'b0;
    #1;
    chk("arst_credit", 32'(credit), 0);
    chk("arst_price",  32'(price), 0);
    chk("arst_cv",     32'(change_valid), 0);
    @(negedge clk) reset = 1'b1;
    tick(3);
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_price = 16'd60; tick(1); cfg_we = 1'b0;
    repeat (3) buy(0, 0, 16'd60, 16'd0);
    chk("post_rst_price", 32'(price), 60);

    // selection timeout: a late column press lands in IDLE
    press_row(0);
    tick(70);
    i0 = n_inv;
    press_col(0);
    chk("timeout_inv", n_inv - i0, 1);

    // credit saturation and refund of the saturated amount
    coin(16'hFFFF); coin(16'h0010);
    chk("sat_credit", 32'(credit), 32'hFFFF);
    push(1'b0, 4'd0, 16'hFFFF);
    do_cancel();
    drain();

    // restock on the dispense cycle wins: three more sales then sold out
    coin(16'd60);
    push(1'b1, 4'd0, 16'd0);
    restock = 1'b1; cfg_idx = 4'd0;
    press_row(0); press_col(0);
    restock = 1'b0;
    drain();
    repeat (3) buy(0, 0, 16'd60, 16'd0);
    coin(16'd60);
    s0 = n_so;
    press_row(0); press_col(0);
    chk("restock_wins", n_so - s0, 1);
    push(1'b0, 4'd0, 16'd60);
    do_cancel();
    drain();

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
